// File: rtl/cordic_angle_sequencer_if.sv
// Step/command bundle between the CORDIC angle sequencer and its datapath.
// Carries the start/mode command, the step handshake and the status pulses.
// master = sequencer side, slave = datapath/controller side.
interface cordic_angle_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 4
);
   logic                  start;
   logic [1:0]            mode;
   logic                  busy;
   logic                  step_valid;
   logic                  step_ready;
   logic [IDX_WIDTH-1:0]  step_index;
   logic [DATA_WIDTH-1:0] step_delta;
   logic                  step_last;
   logic                  done;
   logic                  err;

   modport master (
      input  start, mode, step_ready,
      output busy, step_valid, step_index, step_delta, step_last, done, err
   );

   modport slave (
      output start, mode, step_ready,
      input  busy, step_valid, step_index, step_delta, step_last, done, err
   );
endinterface

// File: rtl/cordic_angle_sequencer.sv
// Purpose: walks the CORDIC shift/angle schedule (circular, linear, hyperbolic with repeats).
// Latency: first step valid the cycle after start; one step per cycle while ready is high.
// Backpressure: step outputs are registered and held while step_valid && !step_ready.
module cordic_angle_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ITERATIONS = 16,
   parameter int IDX_WIDTH  = 4
) (
   input logic clk,
   input logic rst_n,
   cordic_angle_sequencer_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [1:0] MODE_CIRC = 2'd0;
   localparam logic [1:0] MODE_LIN  = 2'd1;
   localparam logic [1:0] MODE_HYP  = 2'd2;
   localparam logic [1:0] MODE_RSVD = 2'd3;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ITERATIONS - 1);
   localparam logic [IDX_WIDTH-1:0] REP_A    = IDX_WIDTH'(4);
   localparam logic [IDX_WIDTH-1:0] REP_B    = IDX_WIDTH'(13);

   state_t                state;
   logic [1:0]            mode_lat;
   logic                  rep;
   logic                  busy_flag;
   logic                  cur_valid;
   logic [IDX_WIDTH-1:0]  cur_idx;
   logic [DATA_WIDTH-1:0] cur_delta;
   logic                  cur_last;
   logic                  done_pulse;
   logic                  err_pulse;

   logic [IDX_WIDTH-1:0]  first_idx;
   logic [IDX_WIDTH-1:0]  next_idx;
   logic                  next_rep;

   // Q2.14 angle tables; linear is simply 2^(14-i), with i=15 underflowing to zero.
   function automatic logic [15:0] table_q14(input logic [1:0] m, input logic [3:0] i);
      logic [15:0] v;
      v = 16'h0000;
      if (m == MODE_CIRC) begin
         case (i)
            4'd0:  v = 16'h3244;
            4'd1:  v = 16'h1DAC;
            4'd2:  v = 16'h0FAE;
            4'd3:  v = 16'h07F5;
            4'd4:  v = 16'h03FF;
            4'd5:  v = 16'h0200;
            4'd6:  v = 16'h0100;
            4'd7:  v = 16'h0080;
            4'd8:  v = 16'h0040;
            4'd9:  v = 16'h0020;
            4'd10: v = 16'h0010;
            4'd11: v = 16'h0008;
            4'd12: v = 16'h0004;
            4'd13: v = 16'h0002;
            default: v = 16'h0001;
         endcase
      end else if (m == MODE_HYP) begin
         case (i)
            4'd1:  v = 16'h2328;
            4'd2:  v = 16'h1059;
            4'd3:  v = 16'h080B;
            4'd4:  v = 16'h0401;
            4'd5:  v = 16'h0200;
            4'd6:  v = 16'h0100;
            4'd7:  v = 16'h0080;
            4'd8:  v = 16'h0040;
            4'd9:  v = 16'h0020;
            4'd10: v = 16'h0010;
            4'd11: v = 16'h0008;
            4'd12: v = 16'h0004;
            4'd13: v = 16'h0002;
            4'd14: v = 16'h0001;
            4'd15: v = 16'h0001;
            default: v = 16'h0000;
         endcase
      end else if (m == MODE_LIN) begin
         v = (i == 4'd15) ? 16'h0000 : (16'h4000 >> i);
      end
      return v;
   endfunction

   // Table values are Q2.14; wider outputs keep the same scale by padding fraction bits.
   function automatic logic [DATA_WIDTH-1:0] scale(input logic [15:0] v);
      return DATA_WIDTH'(v) << (DATA_WIDTH - 16);
   endfunction

   // Hyperbolic convergence needs i=4 and i=13 issued twice; rep marks the first copy done.
   function automatic logic needs_repeat(input logic [1:0] m, input logic [IDX_WIDTH-1:0] i,
                                         input logic r);
      return (m == MODE_HYP) && ((i == REP_A) || (i == REP_B)) && !r;
   endfunction

   // Schedule start point and successor of the step currently presented.
   always_comb begin
      first_idx = (bus.mode == MODE_HYP) ? IDX_WIDTH'(1) : IDX_WIDTH'(0);
      next_idx  = cur_idx + 1'b1;
      next_rep  = 1'b0;
      if (needs_repeat(mode_lat, cur_idx, rep)) begin
         next_idx = cur_idx;
         next_rep = 1'b1;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         mode_lat   <= MODE_CIRC;
         rep        <= 1'b0;
         busy_flag  <= 1'b0;
         cur_valid  <= 1'b0;
         cur_idx    <= '0;
         cur_delta  <= '0;
         cur_last   <= 1'b0;
         done_pulse <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         done_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.mode == MODE_RSVD) begin
                     err_pulse <= 1'b1;
                  end else begin
                     mode_lat  <= bus.mode;
                     rep       <= 1'b0;
                     cur_idx   <= first_idx;
                     cur_delta <= scale(table_q14(bus.mode, 4'(first_idx)));
                     cur_last  <= (first_idx == LAST_IDX) &&
                                  !needs_repeat(bus.mode, first_idx, 1'b0);
                     cur_valid <= 1'b1;
                     busy_flag <= 1'b1;
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               if (cur_valid && bus.step_ready) begin
                  if (cur_last) begin
                     cur_valid  <= 1'b0;
                     cur_last   <= 1'b0;
                     done_pulse <= 1'b1;
                     state      <= DONE;
                  end else begin
                     cur_idx   <= next_idx;
                     rep       <= next_rep;
                     cur_delta <= scale(table_q14(mode_lat, 4'(next_idx)));
                     cur_last  <= (next_idx == LAST_IDX) &&
                                  !needs_repeat(mode_lat, next_idx, next_rep);
                  end
               end
            end
            DONE: begin
               busy_flag <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy       = busy_flag;
   assign bus.step_valid = cur_valid;
   assign bus.step_index = cur_idx;
   assign bus.step_delta = cur_delta;
   assign bus.step_last  = cur_last;
   assign bus.done       = done_pulse;
   assign bus.err        = err_pulse;

endmodule

// File: tb/tb_cordic_angle_sequencer.sv
// Bench for cordic_angle_sequencer: default instance plus DATA_WIDTH=20/N=8 and N=4 variants.
// Expected steps are built from the bench's own tables into a queue and popped per handshake.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cordic_angle_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0]  idx;
      logic [15:0] delta;
      logic        last;
   } step_t;

   typedef struct packed {
      logic [3:0]  idx;
      logic [19:0] delta;
      logic        last;
   } step20_t;

   localparam logic [15:0] CIRC_T [16] = '{
      16'h3244, 16'h1DAC, 16'h0FAE, 16'h07F5, 16'h03FF, 16'h0200, 16'h0100, 16'h0080,
      16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0001};
   localparam logic [15:0] HYP_T [16] = '{
      16'h0000, 16'h2328, 16'h1059, 16'h080B, 16'h0401, 16'h0200, 16'h0100, 16'h0080,
      16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0001};

   cordic_angle_sequencer_if #(.DATA_WIDTH(16), .IDX_WIDTH(4)) sif ();
   cordic_angle_sequencer_if #(.DATA_WIDTH(20), .IDX_WIDTH(4)) sif20 ();
   cordic_angle_sequencer_if #(.DATA_WIDTH(16), .IDX_WIDTH(4)) sif4 ();

   cordic_angle_sequencer #(.DATA_WIDTH(16), .ITERATIONS(16), .IDX_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(sif.master));
   cordic_angle_sequencer #(.DATA_WIDTH(20), .ITERATIONS(8), .IDX_WIDTH(4)) dut20 (
      .clk(clk), .rst_n(rst_n), .bus(sif20.master));
   cordic_angle_sequencer #(.DATA_WIDTH(16), .ITERATIONS(4), .IDX_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(sif4.master));

   function automatic logic [15:0] ref_tbl(input logic [1:0] m, input int i);
      if (m == 2'd0) return CIRC_T[i];
      if (m == 2'd2) return HYP_T[i];
      if (i >= 15) return 16'h0000;
      return 16'(16384 >> i);
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      sif.start = 1'b0;   sif.mode = 2'd0;   sif.step_ready = 1'b1;
      sif20.start = 1'b0; sif20.mode = 2'd0; sif20.step_ready = 1'b1;
      sif4.start = 1'b0;  sif4.mode = 2'd0;  sif4.step_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({sif.busy, sif.step_valid, sif.step_last, sif.done, sif.err, sif.step_index, sif.step_delta} !== 25'd0) begin
         failures++;
         $display("FAIL reset_main: got busy=%b vld=%b last=%b done=%b err=%b idx=%0d delta=%h, want all 0",
                  sif.busy, sif.step_valid, sif.step_last, sif.done, sif.err, sif.step_index, sif.step_delta);
      end
      checks++;
      if ({sif20.busy, sif20.step_valid, sif20.step_delta, sif4.busy, sif4.step_valid, sif4.step_index} !== 28'd0) begin
         failures++;
         $display("FAIL reset_variants: got w20 busy=%b vld=%b delta=%h n4 busy=%b vld=%b idx=%0d, want all 0",
                  sif20.busy, sif20.step_valid, sif20.step_delta, sif4.busy, sif4.step_valid, sif4.step_index);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Runs one full schedule on the default instance, optionally stalling on one index and
   // pulsing start part-way through the run.
   task automatic run_main(input logic [1:0] m, input int stall_at, input int stall_len,
                           input int poke_at, input string tag);
      step_t q[$];
      step_t e;
      int nsteps, hs, cyc, stalls;
      bit fin, poked;
      for (int i = (m == 2'd2) ? 1 : 0; i < 16; i++) begin
         e = '{idx: 4'(i), delta: ref_tbl(m, i), last: 1'b0};
         q.push_back(e);
         if (m == 2'd2 && (i == 4 || i == 13)) q.push_back(e);
      end
      e = q.pop_back();
      e.last = 1'b1;
      q.push_back(e);
      nsteps = q.size();

      @(posedge clk); #1;
      sif.start = 1'b1; sif.mode = m; sif.step_ready = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0; sif.mode = (m == 2'd0) ? 2'd2 : 2'd0;
      hs = 0; cyc = 1; stalls = stall_len; fin = 1'b0; poked = 1'b0;
      while (!fin && cyc < 300) begin
         sif.start = 1'b0;
         if (!poked && poke_at >= 0 && hs == poke_at) begin
            sif.start = 1'b1;
            poked = 1'b1;
         end
         if (sif.step_valid && sif.step_index == 4'(stall_at) && stalls > 0) begin
            sif.step_ready = 1'b0;
            stalls--;
         end else begin
            sif.step_ready = 1'b1;
         end
         @(negedge clk);
         checks++;
         if (!sif.step_valid || q.size() == 0 || sif.err || !sif.busy) begin
            failures++;
            $display("FAIL %s step %0d: got vld=%b busy=%b err=%b with %0d steps left, want vld=1 busy=1 err=0",
                     tag, hs, sif.step_valid, sif.busy, sif.err, q.size());
         end else begin
            e = q[0];
            if ({sif.step_index, sif.step_delta, sif.step_last} !== e) begin
               failures++;
               $display("FAIL %s step %0d: got idx=%0d delta=%h last=%b, want idx=%0d delta=%h last=%b",
                        tag, hs, sif.step_index, sif.step_delta, sif.step_last, e.idx, e.delta, e.last);
            end
            if (sif.step_ready) begin
               void'(q.pop_front());
               hs++;
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (hs == nsteps) fin = 1'b1;
      end
      sif.start = 1'b0;
      sif.step_ready = 1'b1;
      checks++;
      if (!fin || cyc != nsteps + 1 + stall_len) begin
         failures++;
         $display("FAIL %s timing: got %0d handshakes ending at cycle %0d, want %0d ending at cycle %0d",
                  tag, hs, cyc, nsteps, nsteps + 1 + stall_len);
      end
      @(negedge clk);
      checks++;
      if ({sif.done, sif.busy, sif.step_valid, sif.step_last} !== 4'b1100) begin
         failures++;
         $display("FAIL %s done_cycle: got done=%b busy=%b vld=%b last=%b, want 1 1 0 0",
                  tag, sif.done, sif.busy, sif.step_valid, sif.step_last);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({sif.done, sif.busy, sif.step_valid} !== 3'b000) begin
         failures++;
         $display("FAIL %s idle_after: got done=%b busy=%b vld=%b, want 0 0 0",
                  tag, sif.done, sif.busy, sif.step_valid);
      end
   endtask

   task automatic test_circular;
      run_main(2'd0, -1, 0, -1, "circular");
   endtask

   task automatic test_hyperbolic;
      run_main(2'd2, -1, 0, -1, "hyperbolic");
   endtask

   task automatic test_backpressure;
      run_main(2'd0, 2, 3, -1, "backpressure");
   endtask

   task automatic test_start_during_run;
      run_main(2'd0, -1, 0, 5, "start_in_run");
   endtask

   task automatic test_err;
      @(posedge clk); #1;
      sif.start = 1'b1; sif.mode = 2'd3;
      @(posedge clk); #1;
      sif.start = 1'b0; sif.mode = 2'd0;
      @(negedge clk);
      checks++;
      if ({sif.err, sif.busy, sif.step_valid} !== 3'b100) begin
         failures++;
         $display("FAIL err_pulse: got err=%b busy=%b vld=%b, want 1 0 0", sif.err, sif.busy, sif.step_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({sif.err, sif.busy, sif.step_valid} !== 3'b000) begin
         failures++;
         $display("FAIL err_one_cycle: got err=%b busy=%b vld=%b, want 0 0 0", sif.err, sif.busy, sif.step_valid);
      end
   endtask

   task automatic test_reset_mid_run;
      int waited;
      bit seen_done;
      @(posedge clk); #1;
      sif.start = 1'b1; sif.mode = 2'd2; sif.step_ready = 1'b1;
      @(posedge clk); #1;
      sif.start = 1'b0;
      waited = 0;
      while (!(sif.step_valid && sif.step_index == 4'd6) && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      checks++;
      if (waited >= 40) begin
         failures++;
         $display("FAIL midrun_wait: got no index 6 within 40 cycles, want index 6 presented");
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({sif.busy, sif.step_valid, sif.step_last, sif.done, sif.err, sif.step_index, sif.step_delta} !== 25'd0) begin
         failures++;
         $display("FAIL midrun_reset: got busy=%b vld=%b last=%b done=%b err=%b idx=%0d delta=%h, want all 0",
                  sif.busy, sif.step_valid, sif.step_last, sif.done, sif.err, sif.step_index, sif.step_delta);
      end
      seen_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (sif.done || sif.busy || sif.step_valid) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         failures++;
         $display("FAIL midrun_quiet: got activity after reset, want done=0 busy=0 vld=0");
      end
      run_main(2'd1, -1, 0, -1, "linear_after_reset");
   endtask

   task automatic test_width20;
      step20_t q[$];
      step20_t e;
      int cyc;
      for (int i = 0; i < 8; i++) begin
         e = '{idx: 4'(i), delta: {CIRC_T[i], 4'h0}, last: (i == 7)};
         q.push_back(e);
      end
      @(posedge clk); #1;
      sif20.start = 1'b1; sif20.mode = 2'd0; sif20.step_ready = 1'b1;
      @(posedge clk); #1;
      sif20.start = 1'b0;
      cyc = 0;
      while (q.size() > 0 && cyc < 40) begin
         @(negedge clk);
         if (sif20.step_valid) begin
            e = q.pop_front();
            checks++;
            if ({sif20.step_index, sif20.step_delta, sif20.step_last} !== e) begin
               failures++;
               $display("FAIL width20 step: got idx=%0d delta=%h last=%b, want idx=%0d delta=%h last=%b",
                        sif20.step_index, sif20.step_delta, sif20.step_last, e.idx, e.delta, e.last);
            end
         end
         cyc++;
      end
      @(negedge clk);
      checks++;
      if (q.size() != 0 || {sif20.done, sif20.step_valid} !== 2'b10) begin
         failures++;
         $display("FAIL width20 done: got %0d steps missing done=%b vld=%b, want 0 missing done=1 vld=0",
                  q.size(), sif20.done, sif20.step_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_n4_hyper;
      step_t q[$];
      step_t e;
      int cyc;
      for (int i = 1; i < 4; i++) begin
         e = '{idx: 4'(i), delta: HYP_T[i], last: (i == 3)};
         q.push_back(e);
      end
      @(posedge clk); #1;
      sif4.start = 1'b1; sif4.mode = 2'd2; sif4.step_ready = 1'b1;
      @(posedge clk); #1;
      sif4.start = 1'b0;
      cyc = 0;
      while (q.size() > 0 && cyc < 40) begin
         @(negedge clk);
         if (sif4.step_valid) begin
            e = q.pop_front();
            checks++;
            if ({sif4.step_index, sif4.step_delta, sif4.step_last} !== e) begin
               failures++;
               $display("FAIL n4_hyper step: got idx=%0d delta=%h last=%b, want idx=%0d delta=%h last=%b",
                        sif4.step_index, sif4.step_delta, sif4.step_last, e.idx, e.delta, e.last);
            end
         end
         cyc++;
      end
      @(negedge clk);
      checks++;
      if (q.size() != 0 || {sif4.done, sif4.step_valid, sif4.busy} !== 3'b101) begin
         failures++;
         $display("FAIL n4_hyper done: got %0d steps missing done=%b vld=%b busy=%b, want 0 missing done=1 vld=0 busy=1",
                  q.size(), sif4.done, sif4.step_valid, sif4.busy);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_circular;
      test_hyperbolic;
      test_backpressure;
      test_start_during_run;
      test_err;
      test_reset_mid_run;
      test_width20;
      test_n4_hyper;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cordic_angle_sequencer.md
Name: cordic_angle_sequencer

Overview:
Parametrised successor to the fixed 16-entry circular arctan ROM. On a start command it walks the CORDIC iteration schedule for circular, linear or hyperbolic mode and emits one {shift index, delta_z} step per accepted handshake. It sits in front of an iterative or pipelined CORDIC datapath. Hyperbolic mode includes the repeat iterations at i=4 and i=13.

Parameters:
DATA_WIDTH, 16, delta_z width; legal range is >=16; output = Q2.14 table value << (DATA_WIDTH-16)
ITERATIONS, 16, schedule length N; legal range 2..16
IDX_WIDTH, 4, width of the step index output

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  command strobe; accepted only in IDLE
mode  in  2  0=circular, 1=linear, 2=hyperbolic, 3=reserved
busy  out  1  high in RUN and DONE
step_valid  out  1  step_index/step_delta/step_last valid
step_ready  in  1  downstream accepts step
step_index  out  IDX_WIDTH  shift amount i
step_delta  out  DATA_WIDTH  delta_z for this step
step_last  out  1  final step of schedule
done  out  1  one-cycle pulse after final step accepted
err  out  1  one-cycle pulse on start with mode=3

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): state=IDLE. busy, step_valid, step_last, done and err are 0. step_index=0 and step_delta=0. Reset mid-RUN discards the schedule with no done pulse.
- Tables (Q2.14, index 0..15):
  - circular: 3244 1DAC 0FAE 07F5 03FF 0200 0100 0080 0040 0020 0010 0008 0004 0002 0001 0001.
  - hyperbolic atanh(2^-i), i=1..15: 2328 1059 080B 0401 0200 0100 0080 0040 0020 0010 0008 0004 0002 0001 0001. Index 0 is unused.
  - linear: 2^(14-i) for i=0..14; i=15 gives 0000.
- Schedules:
  - circular and linear: i = 0..N-1, giving N steps.
  - hyperbolic: i = 1..N-1. i=4 is emitted twice if N>4, and i=13 twice if N>13. Total steps = N-1 + (N>4) + (N>13).
- States and transitions:
  - IDLE, start=1, mode<3: latch mode, load the first step, go to RUN. step_valid=1 from the next cycle.
  - IDLE, start=1, mode=3: err=1 for one cycle, stay IDLE.
  - RUN: outputs are registered and held stable while step_valid && !step_ready.
  - RUN, handshake (step_valid && step_ready) on a non-last step: advance to the next schedule step. The next step presents the following cycle with no bubble, so one step is delivered per cycle at ready=1.
  - RUN, handshake on the last step: step_valid=0, go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE. busy stays high in DONE.
- Repeat handling: an internal repeat flag is set the first time i=4 or i=13 is emitted in hyperbolic mode. On that step's handshake the index does not advance. The flag clears when the index advances.
- start is ignored while busy=1, and mode changes during RUN have no effect.
- step_last=1 exactly on the final step, and only while step_valid=1.
- Minimum command-to-command spacing: a start is accepted no earlier than the cycle after done.

Test Plan:
- Circular, N=16, ready=1, start at cycle 0 -> step_valid during cycles 1..16; deltas 3244,1DAC,0FAE,...,0001; indices 0..15; step_last on index 15; done at cycle 17; busy low at cycle 18.
- Hyperbolic, N=16 -> 17 steps; indices 1,2,3,4,4,5,...,13,13,14,15; first delta 2328; both index-4 steps carry 0401; step_last on index 15.
- Backpressure: circular, hold step_ready=0 for 3 cycles while index 2 is presented -> index 2 and delta 0FAE held stable; index 3 (07F5) follows the cycle after the handshake; total step count unchanged.
- start pulsed at step 5 during RUN; separately, mode=3 in IDLE -> first pulse ignored with the schedule unaffected; mode=3 gives a one-cycle err pulse with busy staying 0.
- Reset mid-run: rst_n low at hyperbolic step 6 -> next cycle all outputs are 0 and the state is IDLE; no done pulse; a subsequent linear start produces 4000,2000,...
- Parameter variants:
  - DATA_WIDTH=20, N=8, circular -> deltas 32440,1DAC0,... with 8 steps.
  - N=4, hyperbolic -> 3 steps, indices 1,2,3, no repeat.
